carry_select_seq_add: RTL and testbench

CARRY_SELECT_SEQ_ADD -- requirements
Module: carry_select_seq_add

---
 rtl/carry_select_seq_add.sv | 151 +++++++++++++++
 tb/tb_carry_select_seq_add.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_select_seq_add.sv
// Byte-serial adder: one 8-bit carry-select adder reused over NBYTES cycles, LSB byte first.
// Latency: out_valid rises NBYTES cycles after accept; issue-to-issue NBYTES+2 cycles.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready.

module carry_select_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [7:0] sum
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    // Upper nibble is precomputed for both carry values, then picked by the low nibble carry.
    assign lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
    assign hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1  = hi0 + 5'd1;
    assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    assign cout = lo[4] ? hi1[4] : hi0[4];
endmodule

module carry_select_seq_add #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf,
    output logic                busy
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          msb_cin_q, msb_cin_d;

    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          last_byte;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                add_a = a_q[8*i +: 8];
                add_b = b_q[8*i +: 8];
            end
        end
    end

    carry_select_adder8 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .cout (add_cout),
        .sum  (add_sum)
    );

    assign last_byte = (idx_q == IW'(NBYTES - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[8*i +: 8] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (last_byte) begin
                    // Carry into the top bit of the word, recovered from the top byte's operands and sum.
                    msb_cin_d = add_a[7] ^ add_b[7] ^ add_sum[7];
                    state_d   = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
    assign out_ovf   = msb_cin_q ^ carry_q;
endmodule

// File: tb/tb_carry_select_seq_add.sv
// Bench for carry_select_seq_add: directed table and corner sequences on NBYTES=4,
// then concurrent randomized regression on NBYTES=2, 4 and 8 against an arithmetic model.
module tb_carry_select_seq_add;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_r[3];
    logic        in_cin_r[3];
    logic        out_ready_r[3];
    logic [63:0] in_a_r[3];
    logic [63:0] in_b_r[3];
    logic        in_ready_w[3];
    logic        out_valid_w[3];
    logic        out_cout_w[3];
    logic        out_ovf_w[3];
    logic        busy_w[3];
    logic [15:0] sum2;
    logic [31:0] sum4;
    logic [63:0] sum8;
    logic [63:0] out_sum_w[3];

    assign out_sum_w[0] = {48'd0, sum2};
    assign out_sum_w[1] = {32'd0, sum4};
    assign out_sum_w[2] = sum8;

    carry_select_seq_add #(.NBYTES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]),
        .in_a(in_a_r[0][15:0]), .in_b(in_b_r[0][15:0]), .in_cin(in_cin_r[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_r[0]), .out_sum(sum2),
        .out_cout(out_cout_w[0]), .out_ovf(out_ovf_w[0]), .busy(busy_w[0]));

    carry_select_seq_add #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]),
        .in_a(in_a_r[1][31:0]), .in_b(in_b_r[1][31:0]), .in_cin(in_cin_r[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_r[1]), .out_sum(sum4),
        .out_cout(out_cout_w[1]), .out_ovf(out_ovf_w[1]), .busy(busy_w[1]));

    carry_select_seq_add #(.NBYTES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_r[2]), .in_ready(in_ready_w[2]),
        .in_a(in_a_r[2]), .in_b(in_b_r[2]), .in_cin(in_cin_r[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_r[2]), .out_sum(sum8),
        .out_cout(out_cout_w[2]), .out_ovf(out_ovf_w[2]), .busy(busy_w[2]));

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain wide addition, signed overflow from operand/result signs.
    function automatic void model(input int nb, input logic [63:0] a, input logic [63:0] b,
                                  input logic c, output logic [63:0] s,
                                  output logic co, output logic ov);
        logic [63:0] m;
        logic [63:0] am;
        logic [63:0] bm;
        logic [64:0] t;
        int          sb;
        m  = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        am = a & m;
        bm = b & m;
        t  = {1'b0, am} + {1'b0, bm} + 65'(c);
        s  = t[63:0] & m;
        co = t[8 * nb];
        sb = 8 * nb - 1;
        ov = (am[sb] == bm[sb]) && (s[sb] != am[sb]);
    endfunction

    task automatic issue(input int k, input logic [63:0] a, input logic [63:0] b, input logic c);
        int n = 0;
        while (!in_ready_w[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 64'(in_ready_w[k]), 64'd1);
        in_a_r[k]     = a;
        in_b_r[k]     = b;
        in_cin_r[k]   = c;
        in_valid_r[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_r[k] = 1'b0;
    endtask

    task automatic junk(input int k);
        in_valid_r[k]  = 1'($urandom);
        in_cin_r[k]    = 1'($urandom);
        in_a_r[k]      = {$urandom, $urandom};
        in_b_r[k]      = {$urandom, $urandom};
        out_ready_r[k] = 1'($urandom);
    endtask

    task automatic wait_valid(input int k, input bit garbage, output int n);
        n = 0;
        while (!out_valid_w[k] && n < 64) begin
            if (garbage) junk(k);
            @(negedge clk);
            n++;
        end
        out_ready_r[k] = 1'b0;
    endtask

    task automatic consume(input int k);
        in_valid_r[k]  = 1'b0;
        out_ready_r[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_r[k] = 1'b0;
        chk("consume_valid_drop", 64'(out_valid_w[k]), 64'd0);
    endtask

    task automatic run_rand(input int k, input int nb, input int nops);
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic [63:0] es;
        logic        ec;
        logic        eo;
        int          n;
        for (int i = 0; i < nops; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = 1'($urandom);
            case ($urandom_range(0, 7))
                0: a = 64'hFFFF_FFFF_FFFF_FFFF;
                1: b = ~a;
                default: ;
            endcase
            issue(k, a, b, c);
            model(nb, in_a_r[k], in_b_r[k], in_cin_r[k], es, ec, eo);
            wait_valid(k, 1'b1, n);
            chk("rand_latency", 64'(n), 64'(nb));
            repeat ($urandom_range(0, 2)) begin
                junk(k);
                out_ready_r[k] = 1'b0;
                @(negedge clk);
            end
            chk("rand_sum", out_sum_w[k], es);
            chk("rand_cout", 64'(out_cout_w[k]), 64'(ec));
            chk("rand_ovf", 64'(out_ovf_w[k]), 64'(eo));
            consume(k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        tbl[8];
    int          n;
    int          acc;
    int          last;
    bit          pv;
    bit          ok_ready;
    bit          seen;
    logic [63:0] qs[$];
    logic        qc[$];
    logic        qo[$];
    logic [63:0] es;
    logic        ec;
    logic        eo;

    initial begin
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[7] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_r[k] = 1'b0; in_cin_r[k] = 1'b0; out_ready_r[k] = 1'b0;
            in_a_r[k] = '0; in_b_r[k] = '0;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", 64'(in_ready_w[k]), 64'd1);
            chk("reset_out_valid", 64'(out_valid_w[k]), 64'd0);
            chk("reset_busy", 64'(busy_w[k]), 64'd0);
            chk("reset_sum", out_sum_w[k], 64'd0);
            chk("reset_cout", 64'(out_cout_w[k]), 64'd0);
            chk("reset_ovf", 64'(out_ovf_w[k]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(1, 64'(tbl[i].a), 64'(tbl[i].b), tbl[i].c);
            wait_valid(1, 1'b0, n);
            chk("tbl_latency", 64'(n), 64'd4);
            chk("tbl_sum", out_sum_w[1], 64'(tbl[i].s));
            chk("tbl_cout", 64'(out_cout_w[1]), 64'(tbl[i].co));
            chk("tbl_ovf", 64'(out_ovf_w[1]), 64'(tbl[i].ov));
            consume(1);
        end

        // Stalled consumer while new operands churn on the input side.
        issue(1, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0);
        ok_ready = 1'b1;
        n = 0;
        while (!out_valid_w[1] && n < 64) begin
            if (in_ready_w[1]) ok_ready = 1'b0;
            in_valid_r[1] = ~in_valid_r[1];
            in_a_r[1] = {$urandom, $urandom};
            in_b_r[1] = {$urandom, $urandom};
            @(negedge clk);
            n++;
        end
        chk("hold_latency", 64'(n), 64'd4);
        for (int i = 0; i < 5; i++) begin
            chk("hold_sum", out_sum_w[1], 64'h0000_0000_ACF1_3568);
            chk("hold_cout", 64'(out_cout_w[1]), 64'd0);
            chk("hold_ovf", 64'(out_ovf_w[1]), 64'd0);
            chk("hold_valid", 64'(out_valid_w[1]), 64'd1);
            if (in_ready_w[1]) ok_ready = 1'b0;
            in_valid_r[1] = ~in_valid_r[1];
            in_a_r[1] = {$urandom, $urandom};
            in_b_r[1] = {$urandom, $urandom};
            @(negedge clk);
        end
        chk("hold_in_ready_low", 64'(ok_ready), 64'd1);
        consume(1);
        repeat (2) @(negedge clk);
        chk("hold_no_capture_busy", 64'(busy_w[1]), 64'd0);
        chk("hold_no_capture_ready", 64'(in_ready_w[1]), 64'd1);

        // Back-to-back with in_valid and out_ready held high.
        acc = 0; last = -1; pv = 1'b0;
        out_ready_r[1] = 1'b1;
        in_valid_r[1]  = 1'b1;
        for (int t = 0; t < 80 && (acc < 5 || qs.size() > 0); t++) begin
            if (out_valid_w[1]) begin
                chk("b2b_valid_one_cycle", 64'(pv), 64'd0);
                chk("b2b_expected_pending", 64'(qs.size() != 0), 64'd1);
                if (qs.size() != 0) begin
                    chk("b2b_sum", out_sum_w[1], qs.pop_front());
                    chk("b2b_cout", 64'(out_cout_w[1]), 64'(qc.pop_front()));
                    chk("b2b_ovf", 64'(out_ovf_w[1]), 64'(qo.pop_front()));
                end
            end
            if (in_ready_w[1] && acc < 5) begin
                in_a_r[1] = {$urandom, $urandom};
                in_b_r[1] = {$urandom, $urandom};
                in_cin_r[1] = 1'($urandom);
                model(4, in_a_r[1], in_b_r[1], in_cin_r[1], es, ec, eo);
                qs.push_back(es); qc.push_back(ec); qo.push_back(eo);
                if (last >= 0) chk("b2b_spacing", 64'(t - last), 64'd6);
                last = t;
                acc++;
            end else if (in_ready_w[1]) begin
                in_valid_r[1] = 1'b0;
            end
            pv = out_valid_w[1];
            @(negedge clk);
        end
        chk("b2b_accepts", 64'(acc), 64'd5);
        chk("b2b_drained", 64'(qs.size()), 64'd0);
        in_valid_r[1]  = 1'b0;
        out_ready_r[1] = 1'b0;
        @(negedge clk);

        // Reset pulse while an operation is in flight.
        issue(1, 64'h1111_2222, 64'h3333_4444, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready_w[1]), 64'd1);
        chk("rst_mid_busy", 64'(busy_w[1]), 64'd0);
        chk("rst_mid_sum", out_sum_w[1], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_w[1] || busy_w[1]) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_no_result", 64'(seen), 64'd0);
        chk("rst_after_ready", 64'(in_ready_w[1]), 64'd1);
        chk("rst_after_sum", out_sum_w[1], 64'd0);
        issue(1, 64'h0000_0080, 64'h0000_0080, 1'b0);
        wait_valid(1, 1'b0, n);
        chk("rst_next_latency", 64'(n), 64'd4);
        chk("rst_next_sum", out_sum_w[1], 64'h0000_0100);
        chk("rst_next_cout", 64'(out_cout_w[1]), 64'd0);
        chk("rst_next_ovf", 64'(out_ovf_w[1]), 64'd0);
        consume(1);

        fork
            run_rand(0, 2, 3500);
            run_rand(1, 4, 3500);
            run_rand(2, 8, 3500);
        join

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
